fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 109 ++++++++++
 tb/tb_fetch_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer with 2-entry prefetch buffer
// Issues word fetches, buffers responses in order, and flushes on redirect.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        Mem_Req,
    output logic [31:0] Mem_Address,
    input  logic [31:0] Mem_Instruction,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    output logic [31:0] Instruction,
    output logic [31:0] Inst_PC,
    output logic [15:0] Fetch_Count
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] resp_pc_q;
    logic        inflight_q;
    logic [1:0]  count_q;
    logic        head_q;
    logic [15:0] fetch_count_q;
    logic [31:0] hold_instr_q;
    logic [31:0] hold_pc_q;
    logic [31:0] buf_data_q [2];
    logic [31:0] buf_pc_q   [2];

    logic        head_valid;
    logic        pop;
    logic        resp_wr;
    logic        wr_idx;
    logic [2:0]  occupancy;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = Redirect_PC & ~32'h0000_0003;
    assign head_valid   = !reset && (count_q != 2'd0);
    assign pop          = head_valid && Inst_Ready;
    // A response arriving in a redirect cycle belongs to the old stream.
    assign resp_wr      = inflight_q && !Redirect;
    assign wr_idx       = head_q ^ count_q[0];
    assign occupancy    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign Mem_Req      = !reset && !Redirect &&
                          ((state_q != RUN) || (occupancy < 3'(DEPTH)));
    assign Mem_Address  = reset ? RESET_PC : fetch_pc_q;
    assign Inst_Valid   = head_valid;
    assign Instruction  = reset ? 32'h0 : (head_valid ? buf_data_q[head_q] : hold_instr_q);
    assign Inst_PC      = reset ? 32'h0 : (head_valid ? buf_pc_q[head_q] : hold_pc_q);
    assign Fetch_Count  = reset ? 16'h0 : fetch_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= 32'h0;
            inflight_q    <= 1'b0;
            count_q       <= 2'd0;
            head_q        <= 1'b0;
            fetch_count_q <= 16'h0;
            hold_instr_q  <= 32'h0;
            hold_pc_q     <= 32'h0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= 32'h0;
                buf_pc_q[i]   <= 32'h0;
            end
        end else begin
            inflight_q <= Mem_Req;
            if (Mem_Req) begin
                resp_pc_q <= Mem_Address;
            end
            if (head_valid) begin
                hold_instr_q <= buf_data_q[head_q];
                hold_pc_q    <= buf_pc_q[head_q];
            end
            if (pop) begin
                fetch_count_q <= fetch_count_q + 16'd1;
            end
            if (Redirect) begin
                state_q    <= FLUSH;
                fetch_pc_q <= redirect_tgt;
                count_q    <= 2'd0;
                head_q     <= 1'b0;
            end else begin
                state_q <= RUN;
                if (Mem_Req) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                if (resp_wr) begin
                    buf_data_q[wr_idx] <= Mem_Instruction;
                    buf_pc_q[wr_idx]   <= resp_pc_q;
                end
                head_q  <= head_q ^ pop;
                count_q <= count_q + {1'b0, resp_wr} - {1'b0, pop};
            end
        end
    end

    // Request throttling must keep entries + inflight within the buffer.
    assert property (@(posedge clk) disable iff (reset)
        !(resp_wr && (count_q == 2'd2) && !pop));

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_req2;
    logic [31:0] mem_addr, mem_addr2;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] mem_rdata2 = 32'h0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_valid2;
    logic        inst_ready;
    logic [31:0] instruction, instruction2;
    logic [31:0] inst_pc, inst_pc2;
    logic [15:0] fetch_count, fetch_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset(reset),
        .Mem_Req(mem_req), .Mem_Address(mem_addr), .Mem_Instruction(mem_rdata),
        .Redirect(redirect), .Redirect_PC(redirect_pc),
        .Inst_Valid(inst_valid), .Inst_Ready(inst_ready),
        .Instruction(instruction), .Inst_PC(inst_pc), .Fetch_Count(fetch_count)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
        .clk(clk), .reset(reset),
        .Mem_Req(mem_req2), .Mem_Address(mem_addr2), .Mem_Instruction(mem_rdata2),
        .Redirect(1'b0), .Redirect_PC(32'h0),
        .Inst_Valid(inst_valid2), .Inst_Ready(1'b1),
        .Instruction(instruction2), .Inst_PC(inst_pc2), .Fetch_Count(fetch_count2)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0)   return 32'h2005003c;
        if (a == 32'h174) return 32'h20a6fff4;
        return a ^ 32'hDEAD_0000;
    endfunction

    always @(posedge clk) begin
        if (mem_req)  mem_rdata  <= memf(mem_addr);
        if (mem_req2) mem_rdata2 <= memf(mem_addr2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then apply this cycle's inputs and let them settle.
    task automatic cyc(input logic rst, input logic rdy, input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        reset       = rst;
        inst_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
    endtask

    initial begin
        reset = 1'b1; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (3) cyc(1, 0, 0, 0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_count", 32'(fetch_count), 32'h0);
        chk("rst_wrap_addr", mem_addr2, 32'hFFFF_FFFC);

        // Boot with backpressure held
        cyc(0, 0, 0, 0);
        chk("boot_req", 32'(mem_req), 32'h1);
        chk("boot_addr", mem_addr, 32'h0);
        cyc(0, 0, 0, 0);
        chk("c1_req", 32'(mem_req), 32'h1);
        chk("c1_addr", mem_addr, 32'h4);
        chk("c1_valid", 32'(inst_valid), 32'h0);
        cyc(0, 0, 0, 0);
        chk("c2_valid", 32'(inst_valid), 32'h1);
        chk("c2_instr", instruction, 32'h2005003c);
        chk("c2_pc", inst_pc, 32'h0);
        chk("bp_req_drop", 32'(mem_req), 32'h0);
        chk("wrap_pc0", inst_pc2, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0);
        chk("bp_req_drop2", 32'(mem_req), 32'h0);
        chk("bp_pc_hold", inst_pc, 32'h0);
        chk("wrap_pc1", inst_pc2, 32'h0);
        chk("wrap_valid1", 32'(inst_valid2), 32'h1);
        for (int c = 4; c < 7; c++) begin
            cyc(0, 1, 0, 0);
            chk("bp_rel_valid", 32'(inst_valid), 32'h1);
            chk("bp_rel_pc", inst_pc, 32'((c - 4) * 4));
        end
        cyc(0, 0, 0, 0);
        chk("bp_count", 32'(fetch_count), 32'd3);

        // Mid-stream reset, then 20 cycles of streaming
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("mid_rst_valid", 32'(inst_valid), 32'h0);
        chk("mid_rst_count", 32'(fetch_count), 32'h0);
        chk("mid_rst_req", 32'(mem_req), 32'h0);
        for (int c = 0; c < 20; c++) begin
            cyc(0, 1, 0, 0);
            if (c == 0) begin
                chk("rb_req", 32'(mem_req), 32'h1);
                chk("rb_addr", mem_addr, 32'h0);
            end
            if (c == 1) chk("rb_c1_valid", 32'(inst_valid), 32'h0);
            if (c == 2) chk("rb_instr", instruction, 32'h2005003c);
            if (c >= 2) begin
                chk("stream_valid", 32'(inst_valid), 32'h1);
                chk("stream_pc", inst_pc, 32'((c - 2) * 4));
                chk("stream_req", 32'(mem_req), 32'h1);
            end
        end
        cyc(0, 0, 0, 0);
        chk("stream_count", 32'(fetch_count), 32'd18);

        // Redirect at cycle 5 to 0x174
        cyc(1, 0, 0, 0);
        for (int c = 0; c < 5; c++) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 32'h0000_0174);
        chk("rd_no_req", 32'(mem_req), 32'h0);
        chk("rd_pc12", inst_pc, 32'd12);
        cyc(0, 1, 0, 0);
        chk("rd6_valid", 32'(inst_valid), 32'h0);
        chk("rd6_req", 32'(mem_req), 32'h1);
        chk("rd6_addr", mem_addr, 32'h174);
        chk("rd6_hold_pc", inst_pc, 32'd12);
        chk("rd6_hold_instr", instruction, 32'd12 ^ 32'hDEAD_0000);
        chk("rd6_count", 32'(fetch_count), 32'd4);
        cyc(0, 1, 0, 0);
        chk("rd7_valid", 32'(inst_valid), 32'h0);
        cyc(0, 1, 0, 0);
        chk("rd8_valid", 32'(inst_valid), 32'h1);
        chk("rd8_pc", inst_pc, 32'h174);
        chk("rd8_instr", instruction, 32'h20a6fff4);
        cyc(0, 1, 0, 0);
        chk("rd9_pc", inst_pc, 32'h178);

        // Back-to-back redirects: last target wins
        cyc(0, 1, 1, 32'h40);
        cyc(0, 1, 1, 32'h80);
        chk("rr_no_req", 32'(mem_req), 32'h0);
        cyc(0, 1, 0, 0);
        chk("rr_addr", mem_addr, 32'h80);
        chk("rr_valid", 32'(inst_valid), 32'h0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("rr_first_valid", 32'(inst_valid), 32'h1);
        chk("rr_first_pc", inst_pc, 32'h80);

        // Unaligned redirect target
        cyc(0, 1, 1, 32'h43);
        cyc(0, 1, 0, 0);
        chk("ua_req", 32'(mem_req), 32'h1);
        chk("ua_addr", mem_addr, 32'h40);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("ua_pc", inst_pc, 32'h40);
        chk("ua_instr", instruction, 32'h40 ^ 32'hDEAD_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
